// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel/line counters plus registered sync,
// blanking, display-enable and start-of-line/frame strobes, all cycle-aligned.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 800,
  parameter int H_FP      = 40,
  parameter int H_SYNC    = 128,
  parameter int H_BP      = 88,
  parameter int V_ACTIVE  = 600,
  parameter int V_FP      = 1,
  parameter int V_SYNC    = 4,
  parameter int V_BP      = 23,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1,
  parameter int CNT_W     = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             hblnk,
  output logic             vblnk,
  output logic             de,
  output logic             line_start,
  output logic             frame_start
);

  localparam logic [31:0] H_TOTAL = 32'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [31:0] H_ACT   = 32'(H_ACTIVE);
  localparam logic [31:0] H_SS    = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] H_SE    = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] V_TOTAL = 32'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [31:0] V_ACT   = 32'(V_ACTIVE);
  localparam logic [31:0] V_SS    = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] V_SE    = 32'(V_ACTIVE + V_FP + V_SYNC);

  if (64'(H_TOTAL) > (64'(1) << CNT_W)) begin : g_h_too_big
    $error("vga_timing_gen: H_TOTAL exceeds 2**CNT_W");
  end
  if (64'(V_TOTAL) > (64'(1) << CNT_W)) begin : g_v_too_big
    $error("vga_timing_gen: V_TOTAL exceeds 2**CNT_W");
  end

  logic [CNT_W-1:0] hcount_q, hcount_d, vcount_q, vcount_d;
  logic hsync_q, hsync_d, vsync_q, vsync_d;
  logic hblnk_q, hblnk_d, vblnk_q, vblnk_d, de_q, de_d;
  logic line_start_q, line_start_d, frame_start_q, frame_start_d;

  // Decode is taken from the next-state counts so every level output lines up
  // with the counter value registered on the same edge.
  always_comb begin
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    hblnk_d       = hblnk_q;
    vblnk_d       = vblnk_q;
    de_d          = de_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (en) begin
      if (32'(hcount_q) == H_TOTAL - 32'd1) begin
        hcount_d = '0;
        if (32'(vcount_q) == V_TOTAL - 32'd1) vcount_d = '0;
        else                                  vcount_d = vcount_q + CNT_W'(1);
      end else begin
        hcount_d = hcount_q + CNT_W'(1);
      end
      hblnk_d = 32'(hcount_d) >= H_ACT;
      vblnk_d = 32'(vcount_d) >= V_ACT;
      de_d    = !hblnk_d && !vblnk_d;
      hsync_d = (32'(hcount_d) >= H_SS && 32'(hcount_d) < H_SE) ? HSYNC_POL : !HSYNC_POL;
      vsync_d = (32'(vcount_d) >= V_SS && 32'(vcount_d) < V_SE) ? VSYNC_POL : !VSYNC_POL;
      line_start_d  = (hcount_d == '0);
      frame_start_d = (hcount_d == '0) && (vcount_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hsync_q       <= !HSYNC_POL;
      vsync_q       <= !VSYNC_POL;
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      de_q          <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblnk_q       <= hblnk_d;
      vblnk_q       <= vblnk_d;
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign hblnk       = hblnk_q;
  assign vblnk       = vblnk_q;
  assign de          = de_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a small 16x8 mode for directed checks and the
// default 1056x628 mode with inverted sync polarity for a full line.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en, rst2_n, en2;
  logic [10:0] s_h, s_v, d_h, d_v;
  logic s_hs, s_vs, s_hb, s_vb, s_de, s_ls, s_fs;
  logic d_hs, d_vs, d_hb, d_vb, d_de, d_ls, d_fs;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CNT_W(11)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .en(en),
    .hcount(s_h), .vcount(s_v), .hsync(s_hs), .vsync(s_vs),
    .hblnk(s_hb), .vblnk(s_vb), .de(s_de),
    .line_start(s_ls), .frame_start(s_fs)
  );

  vga_timing_gen #(.HSYNC_POL(1'b0), .VSYNC_POL(1'b0)) u_dflt (
    .clk(clk), .rst_n(rst2_n), .en(en2),
    .hcount(d_h), .vcount(d_v), .hsync(d_hs), .vsync(d_vs),
    .hblnk(d_hb), .vblnk(d_vb), .de(d_de),
    .line_start(d_ls), .frame_start(d_fs)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic rst_n, en;
    logic [10:0] h, v;
    logic hs, vs, hb, vb, de, ls, fs;
  } vec_t;

  vec_t vec [21];

  initial begin
    rst_n = 1'b0; en = 1'b0; rst2_n = 1'b0; en2 = 1'b0;
    // rst en   h      v     hs    vs    hb    vb    de    ls    fs
    vec[0]  = '{1'b0, 1'b1, 11'd0,  11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vec[1]  = '{1'b0, 1'b1, 11'd0,  11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vec[2]  = '{1'b0, 1'b1, 11'd0,  11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vec[3]  = '{1'b1, 1'b1, 11'd1,  11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vec[4]  = '{1'b1, 1'b1, 11'd2,  11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vec[5]  = '{1'b1, 1'b1, 11'd3,  11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vec[6]  = '{1'b1, 1'b1, 11'd4,  11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vec[7]  = '{1'b1, 1'b1, 11'd5,  11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vec[8]  = '{1'b1, 1'b1, 11'd6,  11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vec[9]  = '{1'b1, 1'b1, 11'd7,  11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vec[10] = '{1'b1, 1'b1, 11'd8,  11'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[11] = '{1'b1, 1'b1, 11'd9,  11'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[12] = '{1'b1, 1'b1, 11'd10, 11'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[13] = '{1'b1, 1'b1, 11'd11, 11'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[14] = '{1'b1, 1'b1, 11'd12, 11'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[15] = '{1'b1, 1'b1, 11'd13, 11'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[16] = '{1'b1, 1'b1, 11'd14, 11'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[17] = '{1'b1, 1'b1, 11'd15, 11'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[18] = '{1'b1, 1'b1, 11'd0,  11'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vec[19] = '{1'b1, 1'b0, 11'd0,  11'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vec[20] = '{1'b1, 1'b1, 11'd1,  11'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    @(negedge clk);
    // Reset and one full line from the table
    for (int i = 0; i < 21; i++) begin
      rst_n = vec[i].rst_n; en = vec[i].en;
      step();
      chk($sformatf("vec%0d hcount", i), 32'(s_h), 32'(vec[i].h));
      chk($sformatf("vec%0d vcount", i), 32'(s_v), 32'(vec[i].v));
      chk($sformatf("vec%0d hsync", i), 32'(s_hs), 32'(vec[i].hs));
      chk($sformatf("vec%0d vsync", i), 32'(s_vs), 32'(vec[i].vs));
      chk($sformatf("vec%0d hblnk", i), 32'(s_hb), 32'(vec[i].hb));
      chk($sformatf("vec%0d vblnk", i), 32'(s_vb), 32'(vec[i].vb));
      chk($sformatf("vec%0d de", i), 32'(s_de), 32'(vec[i].de));
      chk($sformatf("vec%0d line_start", i), 32'(s_ls), 32'(vec[i].ls));
      chk($sformatf("vec%0d frame_start", i), 32'(s_fs), 32'(vec[i].fs));
    end

    // Free-run three frames
    begin
      int eh, ev, de_cnt, last_fs, n_fs;
      rst_n = 1'b0; en = 1'b1; step(); rst_n = 1'b1;
      de_cnt = int'(s_de); last_fs = -1; n_fs = 0;
      for (int c = 1; c <= 384; c++) begin
        step();
        eh = c % 16; ev = (c / 16) % 8;
        chk("run hcount", 32'(s_h), 32'(eh));
        chk("run vcount", 32'(s_v), 32'(ev));
        chk("run vblnk", 32'(s_vb), 32'(ev >= 4));
        chk("run vsync", 32'(s_vs), 32'(ev == 5 || ev == 6));
        chk("run line_start", 32'(s_ls), 32'(eh == 0));
        chk("run frame_start", 32'(s_fs), 32'(eh == 0 && ev == 0));
        if (c % 128 == 0) begin
          chk("run de per frame", 32'(de_cnt), 32'd32);
          de_cnt = 0;
        end
        de_cnt += int'(s_de);
        if (s_fs) begin
          if (last_fs >= 0) chk("run frame period", 32'(c - last_fs), 32'd128);
          last_fs = c; n_fs++;
        end
      end
      chk("run frame_start count", 32'(n_fs), 32'd3);
    end

    // Enable 1,0,0 repeating for two frames
    begin
      int adv, eh, ev, last_fs, n_fs;
      logic e;
      rst_n = 1'b0; en = 1'b1; step(); rst_n = 1'b1;
      adv = 0; last_fs = -1; n_fs = 0;
      for (int c = 0; c < 768; c++) begin
        e = (c % 3 == 0);
        en = e;
        step();
        if (e) adv++;
        eh = adv % 16; ev = (adv / 16) % 8;
        chk("en hcount", 32'(s_h), 32'(eh));
        chk("en vcount", 32'(s_v), 32'(ev));
        chk("en hsync", 32'(s_hs), 32'(eh >= 10 && eh <= 12));
        chk("en hblnk", 32'(s_hb), 32'(eh >= 8));
        chk("en line_start", 32'(s_ls), 32'(e && eh == 0));
        chk("en frame_start", 32'(s_fs), 32'(e && eh == 0 && ev == 0));
        if (s_fs) begin
          if (last_fs >= 0) chk("en frame period", 32'(c - last_fs), 32'd384);
          last_fs = c; n_fs++;
        end
      end
      chk("en frame_start count", 32'(n_fs), 32'd2);
    end

    // Reset mid-frame at (10,6)
    begin
      int n;
      logic got;
      rst_n = 1'b0; en = 1'b1; step(); rst_n = 1'b1;
      for (int c = 0; c < 106; c++) step();
      chk("mid hcount", 32'(s_h), 32'd10);
      chk("mid vcount", 32'(s_v), 32'd6);
      chk("mid vsync", 32'(s_vs), 32'd1);
      rst_n = 1'b0; step();
      chk("mid rst hcount", 32'(s_h), 32'd0);
      chk("mid rst vcount", 32'(s_v), 32'd0);
      chk("mid rst vsync", 32'(s_vs), 32'd0);
      chk("mid rst hsync", 32'(s_hs), 32'd0);
      chk("mid rst frame_start", 32'(s_fs), 32'd0);
      chk("mid rst line_start", 32'(s_ls), 32'd0);
      rst_n = 1'b1;
      n = 0; got = 1'b0;
      while (n < 200 && !got) begin
        step(); n++;
        if (s_fs) got = 1'b1;
      end
      chk("mid advances to frame_start", 32'(n), 32'd128);
    end

    // Default mode, active-low syncs, one full line
    en = 1'b0;
    rst2_n = 1'b0; en2 = 1'b1; step(); rst2_n = 1'b1;
    chk("dflt rst hcount", 32'(d_h), 32'd0);
    chk("dflt rst hsync", 32'(d_hs), 32'd1);
    chk("dflt rst vsync", 32'(d_vs), 32'd1);
    chk("dflt rst de", 32'(d_de), 32'd1);
    for (int k = 1; k <= 1056; k++) begin
      int eh;
      step();
      eh = k % 1056;
      chk("dflt hcount", 32'(d_h), 32'(eh));
      chk("dflt vcount", 32'(d_v), 32'(k / 1056));
      chk("dflt hsync", 32'(d_hs), 32'(!(eh >= 840 && eh <= 967)));
      chk("dflt hblnk", 32'(d_hb), 32'(eh >= 800));
      chk("dflt vsync", 32'(d_vs), 32'd1);
      chk("dflt line_start", 32'(d_ls), 32'(eh == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
